// File: rtl/id_ex_forward_stage.sv
// rtl/id_ex_forward_stage.sv - ID/EX pipeline register with load-use stall and operand forwarding selects
//
// Purpose: captures the decoded instruction into ID/EX, raises a one-cycle
// load-use stall, counts stall cycles and produces the 4:1 operand mux
// selects for ALU-A, ALU-B and store data.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_*                      decoded instruction from ID
//   flush                     squash the ID instruction
//   exmem_*, memwb_*          downstream writeback intent and destination
//   ex_*                      registered ID/EX fields
//   fwd_sel_a/b/st            mux selects (00 reg, 01 EX/MEM, 10 MEM/WB, 11 imm)
//   stall, stall_cnt          load-use stall and saturating stall counter
module id_ex_forward_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_alu_src,
  input  logic        id_uses_rt,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_alu_src,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [1:0]  fwd_sel_a,
  output logic [1:0]  fwd_sel_b,
  output logic [1:0]  fwd_sel_st,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  logic        valid_q, reg_write_q, mem_read_q, alu_src_q;
  logic        valid_d, reg_write_d, mem_read_d, alu_src_d;
  logic [31:0] rs_data_q, rt_data_q, imm_q;
  logic [31:0] rs_data_d, rt_data_d, imm_d;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_en;
  logic        hit_rs, hit_rt;
  logic        ex_a_hit, wb_a_hit, ex_st_hit, wb_st_hit;

  // The load in EX only delivers its data from MEM, so an ID consumer must
  // wait one cycle. Once the bubble is in EX the condition clears by itself.
  assign hit_rs = (rd_q == id_rs);
  assign hit_rt = id_uses_rt & (rd_q == id_rt);
  assign stall  = id_valid & valid_q & mem_read_q & (rd_q != 5'd0) &
                  (hit_rs | hit_rt) & ~flush;

  assign load_en = id_valid & ~stall & ~flush;

  always_comb begin
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    alu_src_d   = 1'b0;
    rs_data_d   = 32'd0;
    rt_data_d   = 32'd0;
    imm_d       = 32'd0;
    rs_d        = 5'd0;
    rt_d        = 5'd0;
    rd_d        = 5'd0;
    if (load_en) begin
      valid_d     = 1'b1;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      alu_src_d   = id_alu_src;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      rs_d        = id_rs;
      rt_d        = id_rt;
      rd_d        = id_rd;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      alu_src_q   <= 1'b0;
      rs_data_q   <= 32'd0;
      rt_data_q   <= 32'd0;
      imm_q       <= 32'd0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      rd_q        <= 5'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      alu_src_q   <= alu_src_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Register 0 is hard-wired zero, so it never matches a producer.
  assign ex_a_hit  = valid_q & (rs_q != 5'd0) & exmem_reg_write & (exmem_rd == rs_q);
  assign wb_a_hit  = valid_q & (rs_q != 5'd0) & memwb_reg_write & (memwb_rd == rs_q);
  assign ex_st_hit = valid_q & (rt_q != 5'd0) & exmem_reg_write & (exmem_rd == rt_q);
  assign wb_st_hit = valid_q & (rt_q != 5'd0) & memwb_reg_write & (memwb_rd == rt_q);

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    fwd_sel_a = 2'b00;
    if (ex_a_hit) begin
      fwd_sel_a = 2'b01;
    end else if (wb_a_hit) begin
      fwd_sel_a = 2'b10;
    end
  end

  always_comb begin
    fwd_sel_st = 2'b00;
    if (ex_st_hit) begin
      fwd_sel_st = 2'b01;
    end else if (wb_st_hit) begin
      fwd_sel_st = 2'b10;
    end
  end

  assign fwd_sel_b = alu_src_q ? 2'b11 : fwd_sel_st;

  assign ex_valid     = valid_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_alu_src   = alu_src_q;
  assign ex_rs_data   = rs_data_q;
  assign ex_rt_data   = rt_data_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_rd        = rd_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
